// File: rtl/servo_ramp_ctrl.sv
// servo_ramp_ctrl
// Command stage in front of a period-programmable PWM generator that drives an RC servo.
// It takes an 8-bit position command and maps it to a target pulse width in microseconds.
// The current pulse width then slews toward that target by at most STEP_US per PWM frame.
// Duty is only ever rewritten on the last clock of a frame, so the PWM stage picks up
// each new value from the very first count of the next frame.
module servo_ramp_ctrl #(
   parameter int SYS_FREQ  = 125,    // clk counts per microsecond
   parameter int PERIOD_US = 20000,  // PWM frame length in microseconds
   parameter int MIN_US    = 500,    // pulse width for cmd_pos = 0
   parameter int MAX_US    = 2500,   // end of the span; cmd_pos = 255 lands just below it
   parameter int STEP_US   = 10      // largest pulse-width change per frame, at least 1
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [7:0]  cmd_pos,
   output logic [26:0] duty,
   output logic [26:0] pwm_period,
   output logic        period_tick,
   output logic        at_target
);

   // ------------------------------------------------------------------
   // Derived constants
   // ------------------------------------------------------------------
   localparam int PERIOD_CNT = SYS_FREQ * PERIOD_US;
   localparam int FCNT_W     = $clog2(PERIOD_CNT);
   localparam int US_W       = 16;
   localparam int SPAN_US    = MAX_US - MIN_US;
   localparam int CTR_US     = (MIN_US + MAX_US) / 2;

   localparam logic [26:0]       C_PERIOD    = 27'(PERIOD_CNT);
   localparam logic [26:0]       C_CTR_DUTY  = 27'(CTR_US * SYS_FREQ);
   localparam logic [US_W-1:0]   C_CTR_US    = US_W'(CTR_US);
   localparam logic [US_W-1:0]   C_MIN_US    = US_W'(MIN_US);
   localparam logic [US_W-1:0]   C_STEP_US   = US_W'(STEP_US);
   localparam logic [19:0]       C_SPAN_US   = 20'(SPAN_US);
   localparam logic [FCNT_W-1:0] C_FCNT_LAST = FCNT_W'(PERIOD_CNT - 1);
   localparam logic [FCNT_W-1:0] C_FCNT_PRE  = FCNT_W'(PERIOD_CNT - 2);
   localparam logic [FCNT_W-1:0] C_FCNT_ONE  = FCNT_W'(1);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RAMP = 1'b1
   } state_t;

   // ------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------
   logic [FCNT_W-1:0] r_fcnt;
   logic              r_period_tick;
   state_t            r_state;
   logic [US_W-1:0]   r_cur_us;
   logic [US_W-1:0]   r_tgt_us;
   logic [26:0]       r_duty;
   logic              r_cmd_ready;
   logic              r_at_target;

   // ------------------------------------------------------------------
   // Combinational helpers
   // ------------------------------------------------------------------
   logic [19:0]     w_prod;
   logic [US_W-1:0] w_map_us;
   logic [US_W-1:0] w_up_gap;
   logic [US_W-1:0] w_dn_gap;
   logic [US_W-1:0] w_next_us;
   logic [26:0]     w_next_duty;
   logic            w_cmd_accept;

   // Linear map of 0..255 onto MIN_US..MAX_US; the >>8 makes 255 land one LSB short of MAX_US.
   assign w_prod   = 20'(cmd_pos) * C_SPAN_US;
   assign w_map_us = C_MIN_US + US_W'(w_prod >> 8);

   assign w_up_gap = r_tgt_us - r_cur_us;
   assign w_dn_gap = r_cur_us - r_tgt_us;

   assign w_cmd_accept = cmd_valid && r_cmd_ready;

   // Next pulse width: a full STEP_US toward target, or land exactly on it when closer than that.
   always_comb begin
      w_next_us = r_tgt_us;
      if (r_tgt_us > r_cur_us) begin
         if (w_up_gap > C_STEP_US) begin
            w_next_us = r_cur_us + C_STEP_US;
         end
      end else if (r_cur_us > r_tgt_us) begin
         if (w_dn_gap > C_STEP_US) begin
            w_next_us = r_cur_us - C_STEP_US;
         end
      end
   end

   assign w_next_duty = 27'(w_next_us) * 27'(SYS_FREQ);

   // Frame counter and its end-of-frame pulse; the tick is pre-decoded one count early so the
   // registered pulse lines up exactly with the last count of the frame.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_fcnt        <= '0;
         r_period_tick <= 1'b0;
      end else begin
         if (r_fcnt == C_FCNT_LAST) begin
            r_fcnt <= '0;
         end else begin
            r_fcnt <= r_fcnt + C_FCNT_ONE;
         end
         r_period_tick <= (r_fcnt == C_FCNT_PRE);
      end
   end

   // Command/ramp FSM with registered handshake, status and duty outputs.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state     <= ST_IDLE;
         r_cur_us    <= C_CTR_US;
         r_tgt_us    <= C_CTR_US;
         r_duty      <= C_CTR_DUTY;
         r_cmd_ready <= 1'b0;
         r_at_target <= 1'b1;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_cmd_ready <= 1'b1;
               // A command landing on a tick edge is only latched here; the first step waits
               // for the following tick, because stepping only happens in RAMP.
               if (w_cmd_accept) begin
                  r_tgt_us <= w_map_us;
                  if (w_map_us != r_cur_us) begin
                     r_state     <= ST_RAMP;
                     r_at_target <= 1'b0;
                     r_cmd_ready <= 1'b0;
                  end
               end
            end

            ST_RAMP: begin
               // New commands are held off (not dropped) until the target is reached.
               r_cmd_ready <= 1'b0;
               if (r_period_tick) begin
                  r_cur_us <= w_next_us;
                  r_duty   <= w_next_duty;
                  if (w_next_us == r_tgt_us) begin
                     r_state     <= ST_IDLE;
                     r_at_target <= 1'b1;
                     r_cmd_ready <= 1'b1;
                  end
               end
            end

            default: begin
               r_state     <= ST_IDLE;
               r_cmd_ready <= 1'b0;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign cmd_ready   = r_cmd_ready;
   assign duty        = r_duty;
   assign pwm_period  = C_PERIOD;
   assign period_tick = r_period_tick;
   assign at_target   = r_at_target;

endmodule

// File: tb/tb_servo_ramp_ctrl.sv
// Directed bench for servo_ramp_ctrl with a short 100-clock frame.
module tb_servo_ramp_ctrl;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        cmd_valid = 1'b0;
   logic [7:0]  cmd_pos = 8'd0;
   logic        cmd_ready;
   logic [26:0] duty;
   logic [26:0] pwm_period;
   logic        period_tick;
   logic        at_target;

   int checks = 0;
   int passes = 0;

   servo_ramp_ctrl #(
      .SYS_FREQ (10),
      .PERIOD_US(10),
      .MIN_US   (500),
      .MAX_US   (2500),
      .STEP_US  (10)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_pos    (cmd_pos),
      .duty       (duty),
      .pwm_period (pwm_period),
      .period_tick(period_tick),
      .at_target  (at_target)
   );

   always #5 clk = ~clk;

   // Advance to the next falling edge at which period_tick is high (bounded).
   task automatic wait_tick(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 250 && !ok; i++) begin
         @(negedge clk);
         if (period_tick === 1'b1) ok = 1'b1;
      end
   endtask

   task automatic test_reset();
      int first;
      int second;
      int nticks;
      reset_n   = 1'b0;
      cmd_valid = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (cmd_ready !== 1'b0) $display("FAIL reset_ready_low: got %0b want 0", cmd_ready); else passes++;
      checks++; if (duty !== 27'd15000) $display("FAIL reset_duty: got %0d want 15000", duty); else passes++;
      checks++; if (pwm_period !== 27'd100) $display("FAIL reset_period: got %0d want 100", pwm_period); else passes++;
      checks++; if (at_target !== 1'b1) $display("FAIL reset_at_target: got %0b want 1", at_target); else passes++;
      checks++; if (period_tick !== 1'b0) $display("FAIL reset_tick: got %0b want 0", period_tick); else passes++;
      reset_n = 1'b1;
      @(negedge clk);
      checks++; if (cmd_ready !== 1'b1) $display("FAIL reset_ready_after: got %0b want 1", cmd_ready); else passes++;
      first = -1; second = -1; nticks = 0;
      for (int n = 1; n <= 250; n++) begin
         if (n > 1) @(negedge clk);
         if (period_tick === 1'b1) begin
            nticks++;
            if (first < 0) first = n;
            else if (second < 0) second = n;
         end
      end
      checks++; if (first != 99) $display("FAIL reset_first_tick: got %0d want 99", first); else passes++;
      checks++; if (second != 199) $display("FAIL reset_second_tick: got %0d want 199", second); else passes++;
      checks++; if (nticks != 2) $display("FAIL reset_tick_count: got %0d want 2", nticks); else passes++;
      $display("reset: first tick %0d, second tick %0d, duty %0d", first, second, duty);
   endtask

   task automatic test_ramp_up();
      bit ok;
      cmd_pos   = 8'd192;
      cmd_valid = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
      checks++; if (at_target !== 1'b0) $display("FAIL ramp_enter_at_target: got %0b want 0", at_target); else passes++;
      checks++; if (cmd_ready !== 1'b0) $display("FAIL ramp_enter_ready: got %0b want 0", cmd_ready); else passes++;
      checks++; if (duty !== 27'd15000) $display("FAIL ramp_enter_duty: got %0d want 15000", duty); else passes++;
      for (int k = 1; k <= 50; k++) begin
         wait_tick(ok);
         checks++; if (!ok) begin $display("FAIL ramp_tick_timeout: got no tick want tick at step %0d", k); return; end else passes++;
         @(negedge clk);
         checks++; if (duty !== 27'(15000 + 100 * k)) $display("FAIL ramp_step_duty: step %0d got %0d want %0d", k, duty, 15000 + 100 * k); else passes++;
         checks++; if (at_target !== (k == 50)) $display("FAIL ramp_step_at_target: step %0d got %0b want %0b", k, at_target, (k == 50)); else passes++;
      end
      checks++; if (cmd_ready !== 1'b1) $display("FAIL ramp_done_ready: got %0b want 1", cmd_ready); else passes++;
      $display("ramp_up: cmd 192 final duty %0d at_target %0b", duty, at_target);
   endtask

   task automatic test_backpressure();
      int cyc;
      int bad;
      cmd_pos   = 8'd128;
      cmd_valid = 1'b1;
      @(negedge clk);
      cmd_pos = 8'd129;  // second command held on valid during the ramp back to 1500
      checks++; if (at_target !== 1'b0) $display("FAIL bp_enter_at_target: got %0b want 0", at_target); else passes++;
      cyc = 0; bad = 0;
      while (at_target !== 1'b1 && cyc < 6000) begin
         if (cmd_ready !== 1'b0) bad++;
         @(negedge clk);
         cyc++;
      end
      checks++; if (at_target !== 1'b1) $display("FAIL bp_timeout: got at_target %0b want 1", at_target); else passes++;
      checks++; if (bad != 0) $display("FAIL bp_ready_during_ramp: got %0d ready cycles want 0", bad); else passes++;
      checks++; if (duty !== 27'd15000) $display("FAIL bp_arrive_duty: got %0d want 15000", duty); else passes++;
      checks++; if (cmd_ready !== 1'b1) $display("FAIL bp_first_idle_ready: got %0b want 1", cmd_ready); else passes++;
      @(negedge clk);
      cmd_valid = 1'b0;
      checks++; if (cmd_ready !== 1'b0) $display("FAIL bp_second_accept_ready: got %0b want 0", cmd_ready); else passes++;
      checks++; if (at_target !== 1'b0) $display("FAIL bp_second_accept_at_target: got %0b want 0", at_target); else passes++;
      $display("backpressure: ramp took %0d cycles, second command accepted, duty %0d", cyc, duty);
   endtask

   task automatic test_partial_step();
      bit ok;
      checks++; if (duty !== 27'd15000) $display("FAIL partial_start_duty: got %0d want 15000", duty); else passes++;
      wait_tick(ok);
      checks++; if (!ok) $display("FAIL partial_tick_timeout: got no tick want tick"); else passes++;
      checks++; if (duty !== 27'd15000) $display("FAIL partial_tick_cycle_duty: got %0d want 15000", duty); else passes++;
      @(negedge clk);
      checks++; if (duty !== 27'd15070) $display("FAIL partial_duty: got %0d want 15070", duty); else passes++;
      checks++; if (at_target !== 1'b1) $display("FAIL partial_at_target: got %0b want 1", at_target); else passes++;
      checks++; if (cmd_ready !== 1'b1) $display("FAIL partial_ready: got %0b want 1", cmd_ready); else passes++;
      wait_tick(ok);
      @(negedge clk);
      checks++; if (duty !== 27'd15070) $display("FAIL partial_hold_duty: got %0d want 15070", duty); else passes++;
      $display("partial_step: cmd 129 duty %0d at_target %0b", duty, at_target);
   endtask

   task automatic test_noop_collision();
      bit ok;
      int moved;
      // Same position, mid-frame.
      repeat (10) @(negedge clk);
      cmd_pos   = 8'd129;
      cmd_valid = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
      checks++; if (cmd_ready !== 1'b1) $display("FAIL noop_mid_ready: got %0b want 1", cmd_ready); else passes++;
      checks++; if (at_target !== 1'b1) $display("FAIL noop_mid_at_target: got %0b want 1", at_target); else passes++;
      checks++; if (duty !== 27'd15070) $display("FAIL noop_mid_duty: got %0d want 15070", duty); else passes++;
      // Same position, accepted on the tick cycle.
      wait_tick(ok);
      checks++; if (!ok) $display("FAIL noop_tick_timeout: got no tick want tick"); else passes++;
      cmd_valid = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
      checks++; if (at_target !== 1'b1) $display("FAIL noop_tick_at_target: got %0b want 1", at_target); else passes++;
      checks++; if (duty !== 27'd15070) $display("FAIL noop_tick_duty: got %0d want 15070", duty); else passes++;
      // Different position (130 -> 1515 us) accepted on the tick cycle: latched, no move yet.
      wait_tick(ok);
      checks++; if (!ok) $display("FAIL collide_tick_timeout: got no tick want tick"); else passes++;
      cmd_pos   = 8'd130;
      cmd_valid = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
      checks++; if (at_target !== 1'b0) $display("FAIL collide_at_target: got %0b want 0", at_target); else passes++;
      checks++; if (duty !== 27'd15070) $display("FAIL collide_duty_same_edge: got %0d want 15070", duty); else passes++;
      moved = 0;
      repeat (20) begin
         @(negedge clk);
         if (duty !== 27'd15070) moved++;
      end
      checks++; if (moved != 0) $display("FAIL collide_midframe_move: got %0d changed cycles want 0", moved); else passes++;
      wait_tick(ok);
      checks++; if (duty !== 27'd15070) $display("FAIL collide_before_tick_duty: got %0d want 15070", duty); else passes++;
      @(negedge clk);
      checks++; if (duty !== 27'd15150) $display("FAIL collide_next_tick_duty: got %0d want 15150", duty); else passes++;
      checks++; if (at_target !== 1'b1) $display("FAIL collide_next_tick_at_target: got %0b want 1", at_target); else passes++;
      $display("noop_collision: cmd 130 on tick cycle, duty after next tick %0d", duty);
   endtask

   task automatic test_reset_midramp();
      bit ok;
      int first;
      int drift;
      cmd_pos   = 8'd0;
      cmd_valid = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
      checks++; if (at_target !== 1'b0) $display("FAIL midreset_enter_at_target: got %0b want 0", at_target); else passes++;
      for (int k = 1; k <= 19; k++) begin
         wait_tick(ok);
         @(negedge clk);
      end
      checks++; if (duty !== 27'd13250) $display("FAIL midreset_19_steps_duty: got %0d want 13250", duty); else passes++;
      wait_tick(ok);  // 20th tick cycle: reset wins over the step on this edge
      checks++; if (!ok) $display("FAIL midreset_tick_timeout: got no tick want tick"); else passes++;
      reset_n = 1'b0;
      @(negedge clk);
      checks++; if (duty !== 27'd15000) $display("FAIL midreset_duty: got %0d want 15000", duty); else passes++;
      checks++; if (at_target !== 1'b1) $display("FAIL midreset_at_target: got %0b want 1", at_target); else passes++;
      checks++; if (cmd_ready !== 1'b0) $display("FAIL midreset_ready: got %0b want 0", cmd_ready); else passes++;
      checks++; if (period_tick !== 1'b0) $display("FAIL midreset_tick: got %0b want 0", period_tick); else passes++;
      reset_n = 1'b1;
      first = -1; drift = 0;
      for (int n = 1; n <= 150; n++) begin
         @(negedge clk);
         if (period_tick === 1'b1 && first < 0) first = n;
         if (duty !== 27'd15000) drift++;
      end
      checks++; if (first != 99) $display("FAIL midreset_frame_align: got first tick %0d want 99", first); else passes++;
      checks++; if (drift != 0) $display("FAIL midreset_no_more_steps: got %0d moved cycles want 0", drift); else passes++;
      checks++; if (at_target !== 1'b1) $display("FAIL midreset_final_at_target: got %0b want 1", at_target); else passes++;
      $display("reset_midramp: duty %0d, first tick after release %0d", duty, first);
   endtask

   initial begin
      test_reset();
      test_ramp_up();
      test_backpressure();
      test_partial_step();
      test_noop_collision();
      test_reset_midramp();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
